// File: rtl/std_cache_mshr_file.sv
// std_cache_mshr_file: multi-entry miss-status holding register file.
// Tracks up to NUM_MSHR outstanding misses (FREE -> PENDING -> ISSUED -> FREE),
// presents pending misses to the miss handler in allocation order and exposes
// a line-address lookup so the controller can detect collisions.
// Optional feature macro: STD_CACHE_MSHR_MERGE_EN (store merging into a
// PENDING store entry of the same data word).
module std_cache_mshr_file #(
  parameter int NUM_MSHR    = 4,
  parameter int ID_W        = 2,
  parameter int ADDR_W      = 56,
  parameter int DATA_W      = 64,
  parameter int LINE_OFFSET = 4,
  localparam int BE_W  = DATA_W / 8,
  localparam int IDX_W = $clog2(NUM_MSHR),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic [ID_W-1:0]   alloc_id_i,
  input  logic              alloc_we_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic [DATA_W-1:0] alloc_wdata_i,
  input  logic [BE_W-1:0]   alloc_be_i,
  output logic [IDX_W-1:0]  alloc_idx_o,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              lookup_hit_o,
  output logic [IDX_W-1:0]  lookup_idx_o,
  output logic              issue_valid_o,
  input  logic              issue_ready_i,
  output logic [IDX_W-1:0]  issue_idx_o,
  output logic [ID_W-1:0]   issue_id_o,
  output logic              issue_we_o,
  output logic [ADDR_W-1:0] issue_addr_o,
  output logic [DATA_W-1:0] issue_wdata_o,
  output logic [BE_W-1:0]   issue_be_o,
  input  logic              done_valid_i,
  input  logic [IDX_W-1:0]  done_idx_i,
  output logic [CNT_W-1:0]  free_cnt_o,
  output logic              busy_o
);

`ifdef STD_CACHE_MSHR_MERGE_EN
  localparam int WORD_OFF = $clog2(BE_W);
`endif

  typedef enum logic [1:0] {ST_FREE, ST_PENDING, ST_ISSUED} ent_state_e;

  ent_state_e        state_q [NUM_MSHR];
  ent_state_e        state_d [NUM_MSHR];
  logic [ID_W-1:0]   id_q    [NUM_MSHR];
  logic              we_q    [NUM_MSHR];
  logic [ADDR_W-1:0] addr_q  [NUM_MSHR];
  logic [DATA_W-1:0] wdata_q [NUM_MSHR];
  logic [BE_W-1:0]   be_q    [NUM_MSHR];
  logic [IDX_W-1:0]  ord_q   [NUM_MSHR];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, free_cnt_q, free_cnt_d;

  logic             free_found, blocked, merge_hit;
  logic [IDX_W-1:0] free_idx, merge_idx;
  logic             alloc_fire, alloc_new, issue_fire, done_fire;
  logic             unused_lookup_bits;

  // Lookup is line-granular, so the offset bits within a line are irrelevant.
  assign unused_lookup_bits = ^lookup_addr_i[LINE_OFFSET-1:0];

  // Scan registered entries: lowest FREE slot, lookup hit, allocation collision/merge.
  always_comb begin
    free_found   = 1'b0;
    free_idx     = '0;
    blocked      = 1'b0;
    merge_hit    = 1'b0;
    merge_idx    = '0;
    lookup_hit_o = 1'b0;
    lookup_idx_o = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end else begin
        if (addr_q[i][ADDR_W-1:LINE_OFFSET] == lookup_addr_i[ADDR_W-1:LINE_OFFSET]) begin
          lookup_hit_o = 1'b1;
          lookup_idx_o = IDX_W'(i);
        end
        if (addr_q[i][ADDR_W-1:LINE_OFFSET] == alloc_addr_i[ADDR_W-1:LINE_OFFSET]) begin
`ifdef STD_CACHE_MSHR_MERGE_EN
          if (alloc_we_i && (state_q[i] == ST_PENDING) && we_q[i] &&
              (addr_q[i][ADDR_W-1:WORD_OFF] == alloc_addr_i[ADDR_W-1:WORD_OFF])) begin
            merge_hit = 1'b1;
            merge_idx = IDX_W'(i);
          end else begin
            blocked = 1'b1;
          end
`else
          blocked = 1'b1;
`endif
        end
      end
    end
  end

  assign alloc_ready_o = !blocked && (merge_hit || free_found);
  assign alloc_idx_o   = merge_hit ? merge_idx : free_idx;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign alloc_new     = alloc_fire && !merge_hit;

  assign issue_valid_o = (cnt_q != '0);
  assign issue_idx_o   = ord_q[head_q];
  assign issue_id_o    = id_q[issue_idx_o];
  assign issue_we_o    = we_q[issue_idx_o];
  assign issue_addr_o  = addr_q[issue_idx_o];
  assign issue_wdata_o = wdata_q[issue_idx_o];
  assign issue_be_o    = be_q[issue_idx_o];
  assign issue_fire    = issue_valid_o && issue_ready_i;

  // Done only releases ISSUED entries; anything else is a stray completion.
  assign done_fire = done_valid_i && (state_q[done_idx_i] == ST_ISSUED);

  assign free_cnt_o = free_cnt_q;
  assign busy_o     = (free_cnt_q != CNT_W'(NUM_MSHR));

  // Entry lifecycle, queue pointers and counters; the three transitions hit
  // entries in distinct states, so they never target the same slot.
  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) state_d[i] = state_q[i];
    if (issue_fire) state_d[issue_idx_o] = ST_ISSUED;
    if (done_fire)  state_d[done_idx_i]  = ST_FREE;
    if (alloc_new)  state_d[free_idx]    = ST_PENDING;
    head_d     = issue_fire ? head_q + IDX_W'(1) : head_q;
    tail_d     = alloc_new  ? tail_q + IDX_W'(1) : tail_q;
    cnt_d      = cnt_q + CNT_W'(alloc_new) - CNT_W'(issue_fire);
    free_cnt_d = free_cnt_q - CNT_W'(alloc_new) + CNT_W'(done_fire);
  end

  // Register state, order queue and entry payloads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i] <= ST_FREE;
        id_q[i]    <= '0;
        we_q[i]    <= 1'b0;
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
        ord_q[i]   <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      free_cnt_q <= CNT_W'(NUM_MSHR);
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) state_q[i] <= state_d[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
      free_cnt_q <= free_cnt_d;
      if (alloc_new) begin
        ord_q[tail_q]     <= free_idx;
        id_q[free_idx]    <= alloc_id_i;
        we_q[free_idx]    <= alloc_we_i;
        addr_q[free_idx]  <= alloc_addr_i;
        wdata_q[free_idx] <= alloc_wdata_i;
        be_q[free_idx]    <= alloc_be_i;
      end
`ifdef STD_CACHE_MSHR_MERGE_EN
      else if (alloc_fire) begin
        id_q[merge_idx] <= alloc_id_i;
        be_q[merge_idx] <= be_q[merge_idx] | alloc_be_i;
        for (int b = 0; b < BE_W; b++) begin
          if (alloc_be_i[b]) wdata_q[merge_idx][8*b +: 8] <= alloc_wdata_i[8*b +: 8];
        end
      end
`endif
    end
  end

endmodule
